trace_recorder_mc: RTL
======================

Name: trace_recorder_mc

Overview:
- Multi-channel, parametrised successor of the single-probe ISR/DMA debug recorder.
- Watches NUM_CH valid/ready probe channels and timestamps the first request cycle and the acceptance cycle of each transaction, tagging each entry with channel ID and opcode.
- Packs entries into DATA_WIDTH lines stored in on-chip RAM.
- Adds a tag trigger, a circular/stop-on-full mode, flush of partial lines and a drop counter; host readback goes through a port arbitrated against RAM writes.

Parameters:
- DATA_WIDTH, 256, RAM line width and read data width.
- ADDR_WIDTH, 10, RAM depth is 2**ADDR_WIDTH lines.
- NUM_CH, 4, number of probe channels (>=2).
- TAG_WIDTH, 5, per-channel opcode/tag width.
- TSTAMP_WIDTH, 32, timestamp counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- ch_valid  in  NUM_CH  per-channel valid probe.
- ch_ready  in  NUM_CH  per-channel ready probe.
- ch_tag  in  NUM_CH*TAG_WIDTH  per-channel tag; channel c occupies [c*TAG_WIDTH+:TAG_WIDTH].
- trig_in  in  1  external trigger pulse.
- cfg_circ  in  1  1 = circular buffer, 0 = stop when full.
- cfg_trig_tag  in  TAG_WIDTH  tag that fires the trigger while ARMED.
- cmd_valid  in  1  command strobe.
- cmd  in  3  command code.
- rd_re  in  1  readback request.
- rd_addr  in  ADDR_WIDTH  readback line address.
- rd_gnt  out  1  rd_re accepted this cycle (combinational).
- rd_valid  out  1  rd_dout valid.
- rd_dout  out  DATA_WIDTH  readback line.
- st_state  out  3  FSM state encoding.
- st_wr_ptr  out  ADDR_WIDTH  next line address to write.
- st_wrapped  out  1  circular buffer has wrapped at least once.
- st_drop_cnt  out  16  events dropped, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; timestamp, pointer, slot, per-channel wait flags, line buffer, wrapped flag and drop count all 0.
- Entry layout, MSB to LSB: {ch_id[CH_W], req, ack, tag, tstamp}, where CH_W = clog2(NUM_CH).
  - ENTRY_W = CH_W + 2 + TAG_WIDTH + TSTAMP_WIDTH (41 at defaults).
  - SLOTS = DATA_WIDTH / ENTRY_W (6 at defaults); elaboration error if SLOTS < 1.
  - Slot k occupies [k*ENTRY_W+:ENTRY_W]; upper unused bits are 0.
- Event detection per channel c:
  - req = valid & !wait_c; ack = valid & ready.
  - wait_c <= valid & !ready while RECORD; wait_c is cleared outside RECORD.
  - An event is req | ack; a single-cycle handshake yields one entry with req = 1 and ack = 1.
- Arbitration: at most one entry is recorded per cycle. The lowest-index event channel wins. Each other event in the same cycle increments st_drop_cnt by 1, saturating at 0xFFFF.
- Timestamp increments every RECORD cycle and wraps modulo 2**TSTAMP_WIDTH. The entry carries the pre-increment value.
- Line assembly:
  - The winning entry goes into line-buffer slot `slot`, and slot increments.
  - When slot == SLOTS-1, the completed line is written to RAM[wr_ptr] on the next cycle, wr_ptr increments, and slot returns to 0.
  - The buffer is double-registered so back-to-back events never stall.
- FSM states and transitions:
  - IDLE = 0: waits for commands.
  - ARMED = 1: moves to RECORD on trig_in, or on any ch_valid with req whose tag == cfg_trig_tag. That triggering event is recorded with tstamp 0.
  - RECORD = 2: records events as above.
  - FLUSH = 3: one cycle. If slot != 0, writes the partial line with unfilled slots 0, then advances wr_ptr and clears slot. Then goes to IDLE.
  - FULL = 4: reached when a line write hits address 2**ADDR_WIDTH-1 with cfg_circ = 0. Events are ignored in FULL.
- Wrap: with cfg_circ = 1, wr_ptr wraps to 0 and st_wrapped is set. st_wrapped stays set until CLEAR.
- Commands take effect on the next cycle; unlisted codes are ignored.
  - 0 START: IDLE/ARMED -> RECORD.
  - 1 STOP: RECORD/ARMED -> FLUSH.
  - 2 CLEAR: only in IDLE/FULL; zeroes timestamp, wr_ptr, slot, st_wrapped and st_drop_cnt; FULL -> IDLE.
  - 3 ARM: IDLE -> ARMED.
- Readback:
  - rd_gnt = rd_re & no RAM write this cycle.
  - On grant, rd_dout holds RAM[rd_addr] one cycle later with rd_valid = 1.
  - Without a grant the requester must hold rd_re.
  - RAM is read-first on address collision.
- Reset mid-record: the partial line is lost and RAM contents are preserved. There is no RAM reset.

Optional Feature:
- Macro: TRACE_CH_FILTER_EN.
- With the macro: adds input cfg_ch_en[NUM_CH]. Channels with cfg_ch_en = 0 generate no events, do not participate in arbitration or the trigger, and never count as drops.
- Without the macro: all channels are always enabled and the port is absent.

Decomposition:
- Shared package trace_pkg holds:
  - the trace_state_t enum;
  - the trace_cmd_t enum (START, STOP, CLEAR, ARM);
  - the ENTRY_W and SLOTS computation functions;
  - the entry packed-struct typedef.
- Sub-module trace_ram: behavioural simple-dual-port RAM, 1-cycle read, read-first.

Test Plan:
- Reset, START, then ch0 valid for 3 cycles with ready on the third -> two entries: {0,1,0,tag,t0} and {0,0,1,tag,t0+2}.
- ch1 and ch3 both issue single-cycle handshakes in the same cycle -> only ch1 is recorded with req = ack = 1, and st_drop_cnt = 1.
- 6 events, then STOP after 2 more -> RAM[0] holds 6 entries, RAM[1] holds 2 entries with upper slots 0, st_wr_ptr = 2, state IDLE.
- ADDR_WIDTH = 2, cfg_circ = 0, 24 events -> FULL after line 3; a 25th event is ignored; CLEAR -> IDLE with st_wr_ptr = 0.
- Same as above with cfg_circ = 1 and 30 events -> st_wrapped = 1, st_wr_ptr = 1, RAM[0] holds events 25–30.
- ARM with cfg_trig_tag = 0x07; ch2 sends tag 0x03, then tag 0x07 -> only the 0x07 event is recorded, at tstamp 0. rd_re during a line write -> rd_gnt = 0; on the next cycle rd_gnt = 1 and rd_valid follows one cycle later.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the multi-channel trace recorder.
package trace_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_RECORD = 3'd2,
      S_FLUSH  = 3'd3,
      S_FULL   = 3'd4
   } trace_state_t;

   typedef enum logic [2:0] {
      CMD_START = 3'd0,
      CMD_STOP  = 3'd1,
      CMD_CLEAR = 3'd2,
      CMD_ARM   = 3'd3
   } trace_cmd_t;

   localparam int DEF_CH_W  = 2;
   localparam int DEF_TAG_W = 5;
   localparam int DEF_TS_W  = 32;

   // Entry view at the default channel/tag/timestamp widths
   typedef struct packed {
      logic [DEF_CH_W-1:0]  ch_id;
      logic                 req;
      logic                 ack;
      logic [DEF_TAG_W-1:0] tag;
      logic [DEF_TS_W-1:0]  tstamp;
   } trace_entry_t;

   function automatic int calc_entry_w(input int num_ch, input int tag_w, input int ts_w);
      return $clog2(num_ch) + 2 + tag_w + ts_w;
   endfunction

   function automatic int calc_slots(input int data_w, input int entry_w);
      return data_w / entry_w;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port line RAM: one write port, one read port with 1-cycle read-first data.
module trace_ram
   import trace_pkg::*;
#(
   parameter int DW = 256,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(2**AW)-1];

   // Storage array has no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register sees the old word on a same-cycle write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_o <= '0;
      end else if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/trace_recorder_mc.sv
// Multi-channel valid/ready transaction recorder packing timestamped entries into RAM lines.
// Define TRACE_CH_FILTER_EN to add the per-channel enable input cfg_ch_en.
module trace_recorder_mc
   import trace_pkg::*;
#(
   parameter int DATA_WIDTH   = 256,
   parameter int ADDR_WIDTH   = 10,
   parameter int NUM_CH       = 4,
   parameter int TAG_WIDTH    = 5,
   parameter int TSTAMP_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             ch_valid,
   input  logic [NUM_CH-1:0]             ch_ready,
   input  logic [NUM_CH*TAG_WIDTH-1:0]   ch_tag,
`ifdef TRACE_CH_FILTER_EN
   input  logic [NUM_CH-1:0]             cfg_ch_en,
`endif
   input  logic                          trig_in,
   input  logic                          cfg_circ,
   input  logic [TAG_WIDTH-1:0]          cfg_trig_tag,
   input  logic                          cmd_valid,
   input  logic [2:0]                    cmd,
   input  logic                          rd_re,
   input  logic [ADDR_WIDTH-1:0]         rd_addr,
   output logic                          rd_gnt,
   output logic                          rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_dout,
   output logic [2:0]                    st_state,
   output logic [ADDR_WIDTH-1:0]         st_wr_ptr,
   output logic                          st_wrapped,
   output logic [15:0]                   st_drop_cnt
);

   localparam int CH_W    = $clog2(NUM_CH);
   localparam int ENTRY_W = calc_entry_w(NUM_CH, TAG_WIDTH, TSTAMP_WIDTH);
   localparam int SLOTS   = calc_slots(DATA_WIDTH, ENTRY_W);
   localparam int SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int NEV_W   = CH_W + 1;
   localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = '1;
   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SLOTS - 1);

   if (SLOTS < 1) begin : g_slots_chk
      $error("trace_recorder_mc: DATA_WIDTH cannot hold a single entry");
   end

   trace_state_t                  state_q, state_d;
   logic [TSTAMP_WIDTH-1:0]       ts_q, ts_d, ts_ent_s;
   logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
   logic [SLOT_W-1:0]             slot_q, slot_d;
   logic [SLOTS-1:0][ENTRY_W-1:0] buf_q, buf_d;
   logic [DATA_WIDTH-1:0]         wline_q, wline_d, wdata_s;
   logic                          pend_q, pend_d, wrapped_q, wrapped_d, rd_valid_q;
   logic [15:0]                   drop_q, drop_d;
   logic [16:0]                   dsum_s;
   logic [NUM_CH-1:0]             wait_q, wait_d, en_s, req_s, ack_s, hit_s, cand_s;
   logic [TAG_WIDTH-1:0]          tag_s [NUM_CH];
   logic                          found_s;
   logic [CH_W-1:0]               win_s;
   logic [NEV_W-1:0]              nev_s;
   logic [ENTRY_W-1:0]            entry_s;
   logic                          start_s, stop_s, clear_s, arm_s, trig_s, rec_s, we_s;

   function automatic logic [DATA_WIDTH-1:0] pack_line(input logic [SLOTS-1:0][ENTRY_W-1:0] b);
      logic [DATA_WIDTH-1:0] l;
      l = '0;
      l[SLOTS*ENTRY_W-1:0] = b;
      return l;
   endfunction

`ifdef TRACE_CH_FILTER_EN
   assign en_s = cfg_ch_en;
`else
   assign en_s = '1;
`endif

   assign start_s  = cmd_valid && (cmd == CMD_START);
   assign stop_s   = cmd_valid && (cmd == CMD_STOP);
   assign clear_s  = cmd_valid && (cmd == CMD_CLEAR);
   assign arm_s    = cmd_valid && (cmd == CMD_ARM);
   assign trig_s   = (state_q == S_ARMED) && (trig_in || (|hit_s)) && !stop_s;
   assign rec_s    = (state_q == S_RECORD) || trig_s;
   assign cand_s   = (state_q == S_RECORD) ? (req_s | ack_s) : (trig_s ? hit_s : '0);
   assign ts_ent_s = trig_s ? '0 : ts_q;
   assign entry_s  = {win_s, req_s[win_s], ack_s[win_s], tag_s[win_s], ts_ent_s};
   assign dsum_s   = {1'b0, drop_q} + 17'(nev_s) - 17'd1;

   // Per-channel request/acknowledge decode
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         tag_s[c] = ch_tag[c*TAG_WIDTH +: TAG_WIDTH];
         req_s[c] = ch_valid[c] & en_s[c] & ~wait_q[c];
         ack_s[c] = ch_valid[c] & en_s[c] & ch_ready[c];
         hit_s[c] = req_s[c] & (tag_s[c] == cfg_trig_tag);
      end
   end

   // Lowest-index channel wins; every other candidate is a drop
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      nev_s   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cand_s[c]) begin
            nev_s = nev_s + NEV_W'(1);
            if (!found_s) begin
               found_s = 1'b1;
               win_s   = CH_W'(c);
            end
         end
      end
   end

   // Next-state: RAM write, line assembly, commands
   always_comb begin
      state_d   = state_q;
      ts_d      = ts_q;
      wr_ptr_d  = wr_ptr_q;
      slot_d    = slot_q;
      buf_d     = buf_q;
      wline_d   = wline_q;
      pend_d    = 1'b0;
      wrapped_d = wrapped_q;
      drop_d    = drop_q;
      wait_d    = '0;
      we_s      = 1'b0;
      wdata_s   = wline_q;

      if (pend_q && (state_q != S_FULL)) begin
         we_s = 1'b1;
      end else if ((state_q == S_FLUSH) && (slot_q != '0)) begin
         we_s    = 1'b1;
         wdata_s = pack_line(buf_q);
         slot_d  = '0;
         buf_d   = '0;
      end else begin
         we_s = 1'b0;
      end

      if (we_s) begin
         if (wr_ptr_q != PTR_MAX) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         end else if (cfg_circ) begin
            wr_ptr_d  = '0;
            wrapped_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
      end

      if (rec_s) begin
         wait_d = ch_valid & en_s & ~ch_ready;
         ts_d   = trig_s ? TSTAMP_WIDTH'(1) : ts_q + TSTAMP_WIDTH'(1);
         if (found_s) begin
            buf_d[slot_q] = entry_s;
            drop_d = dsum_s[16] ? 16'hFFFF : dsum_s[15:0];
            if (slot_q == SLOT_LAST) begin
               pend_d  = 1'b1;
               wline_d = pack_line(buf_d);
               buf_d   = '0;
               slot_d  = '0;
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_RECORD;
            end else if (arm_s) begin
               state_d = S_ARMED;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARMED: begin
            if (stop_s) begin
               state_d = S_FLUSH;
            end else if (start_s || trig_s) begin
               state_d = S_RECORD;
            end else begin
               state_d = S_ARMED;
            end
         end
         S_RECORD: state_d = stop_s ? S_FLUSH : S_RECORD;
         S_FLUSH:  state_d = S_IDLE;
         S_FULL:   state_d = clear_s ? S_IDLE : S_FULL;
         default:  state_d = S_IDLE;
      endcase

      if (clear_s && ((state_q == S_IDLE) || (state_q == S_FULL))) begin
         ts_d      = '0;
         wr_ptr_d  = '0;
         slot_d    = '0;
         buf_d     = '0;
         wrapped_d = 1'b0;
         drop_d    = '0;
      end

      if (we_s && (wr_ptr_q == PTR_MAX) && !cfg_circ) begin
         state_d = S_FULL;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         slot_q     <= '0;
         buf_q      <= '0;
         wline_q    <= '0;
         pend_q     <= 1'b0;
         wrapped_q  <= 1'b0;
         drop_q     <= '0;
         wait_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         wr_ptr_q   <= wr_ptr_d;
         slot_q     <= slot_d;
         buf_q      <= buf_d;
         wline_q    <= wline_d;
         pend_q     <= pend_d;
         wrapped_q  <= wrapped_d;
         drop_q     <= drop_d;
         wait_q     <= wait_d;
         rd_valid_q <= rd_gnt;
      end
   end

   assign rd_gnt      = rd_re & ~we_s;
   assign rd_valid    = rd_valid_q;
   assign st_state    = state_q;
   assign st_wr_ptr   = wr_ptr_q;
   assign st_wrapped  = wrapped_q;
   assign st_drop_cnt = drop_q;

   trace_ram #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata_s),
      .re_i    (rd_gnt),
      .raddr_i (rd_addr),
      .rdata_o (rd_dout)
   );

endmodule
